mem_port_arbiter: RTL and testbench

Arbitrates the single data-memory port between the pipeline's memory stage and an external requester (DMA / I/O loader). On an external request it raises HOLD to the stage-3 pipeline register, which stalls the pipeline with a bubble and saves the in-flight instruction. Once the pipeline instruction has drained, the arbiter grants the port to the external side for a bounded burst, then returns it. It sits between the stage-3 register outputs (M3, DATA_ADDR_3) and the data memory.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 87 ++++++++
 tb/tb_mem_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline, external requester and data-memory signals of the port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic [1:0]        M3;
    logic [ADDR_W-1:0] DATA_ADDR_3;
    logic [DATA_W-1:0] WDATA_3;
    logic              EXT_REQ;
    logic              EXT_WE;
    logic [ADDR_W-1:0] EXT_ADDR;
    logic [DATA_W-1:0] EXT_WDATA;
    logic              EXT_GNT;
    logic              EXT_ACK;
    logic [DATA_W-1:0] EXT_RDATA;
    logic              HOLD;
    logic              MEM_EN;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              CONFLICT;

    modport slave (
        input  M3, DATA_ADDR_3, WDATA_3, EXT_REQ, EXT_WE, EXT_ADDR, EXT_WDATA, MEM_RDATA,
        output EXT_GNT, EXT_ACK, EXT_RDATA, HOLD, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, CONFLICT
    );

    modport master (
        output M3, DATA_ADDR_3, WDATA_3, EXT_REQ, EXT_WE, EXT_ADDR, EXT_WDATA, MEM_RDATA,
        input  EXT_GNT, EXT_ACK, EXT_RDATA, HOLD, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, CONFLICT
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the data-memory port between stage 3 and an external burst requester.
// Define ARB_CONFLICT_CHK_EN to enable the sticky CONFLICT check.
module mem_port_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4,
    parameter int PIPE_GAP  = 2
) (
    input logic CLK,
    input logic RST,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {PIPE, DRAIN, EXT} state_t;

    localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

    state_t     state;
    logic       hold;
    logic       gnt;
    logic       ack;
    logic       accept;
    logic       pipe_op;
    logic [3:0] burst;
    logic [3:0] gap;

    assign accept  = gnt & bus.EXT_REQ;
    assign pipe_op = (bus.M3 == 2'b01) | (bus.M3 == 2'b10);

    assign bus.HOLD      = hold;
    assign bus.EXT_GNT   = gnt;
    assign bus.EXT_ACK   = ack;
    assign bus.EXT_RDATA = ack ? bus.MEM_RDATA : DATA_W'(0);
    assign bus.MEM_EN    = gnt ? bus.EXT_REQ : pipe_op;
    assign bus.MEM_WE    = gnt ? bus.EXT_REQ & bus.EXT_WE : bus.M3 == 2'b10;
    assign bus.MEM_ADDR  = gnt ? ADDR_W'(bus.EXT_ADDR) : ADDR_W'(bus.DATA_ADDR_3);
    assign bus.MEM_WDATA = gnt ? bus.EXT_WDATA : bus.WDATA_3;

    // hold and gnt are registered decodes of the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= PIPE;
            hold  <= 1'b0;
            gnt   <= 1'b0;
            ack   <= 1'b0;
            burst <= 4'd0;
            gap   <= 4'd0;
        end else begin
            ack <= accept;
            case (state)
                PIPE: begin
                    if (gap != 4'd0) gap <= gap - 4'd1;
                    else if (bus.EXT_REQ) begin
                        state <= DRAIN;
                        hold  <= 1'b1;
                    end
                end
                DRAIN: begin
                    state <= EXT;
                    gnt   <= 1'b1;
                    burst <= 4'd0;
                end
                EXT: begin
                    if (!bus.EXT_REQ || burst == LAST) begin
                        state <= PIPE;
                        hold  <= 1'b0;
                        gnt   <= 1'b0;
                        gap   <= bus.EXT_REQ ? 4'(PIPE_GAP) : 4'd0;
                    end else burst <= burst + 4'd1;
                end
                default: begin
                    state <= PIPE;
                    hold  <= 1'b0;
                    gnt   <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_CONFLICT_CHK_EN
    logic conflict;
    // a live pipeline op while external owns the port means stage 3 failed to bubble
    always_ff @(posedge CLK) conflict <= RST ? 1'b0 : conflict | (gnt & pipe_op);
    assign bus.CONFLICT = conflict;
`else
    assign bus.CONFLICT = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of reset, pipeline pass-through, drain, single read, burst limit and conflict.
module tb_mem_port_arbiter;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   failures = 0;
    int   acks = 0;
    logic [8:0]  hold_v, gnt_v, ack_v;
    logic [15:0] mem [0:2047];

`ifdef ARB_CONFLICT_CHK_EN
    localparam logic CONF_EXP = 1'b1;
`else
    localparam logic CONF_EXP = 1'b0;
`endif

    mem_port_arbiter_if #(.ADDR_W(11), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(11), .DATA_W(16), .MAX_BURST(4), .PIPE_GAP(2)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // synchronous-read memory, preloaded at reset with the word the single-read test fetches
    always @(posedge CLK) begin
        if (RST) mem[11'h010] <= 16'h1234;
        else if (bus.MEM_EN && bus.MEM_WE) mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
        if (bus.MEM_EN && !bus.MEM_WE) bus.MEM_RDATA <= mem[bus.MEM_ADDR];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.M3 = 2'b00;
        bus.DATA_ADDR_3 = '0;
        bus.WDATA_3 = '0;
        bus.EXT_REQ = 1'b1;
        bus.EXT_WE = 1'b0;
        bus.EXT_ADDR = '0;
        bus.EXT_WDATA = '0;
        bus.MEM_RDATA = '0;
        tick();
        tick();
        chk("rst_hold", bus.HOLD, 0);
        chk("rst_gnt", bus.EXT_GNT, 0);
        chk("rst_ack", bus.EXT_ACK, 0);
        chk("rst_conflict", bus.CONFLICT, 0);
        chk("rst_rdata", bus.EXT_RDATA, 0);
        RST = 1'b0;
        tick();
        chk("post_rst_hold", bus.HOLD, 1);
        chk("post_rst_gnt", bus.EXT_GNT, 0);
        bus.EXT_REQ = 1'b0;
        tick();
        chk("idle_grant_gnt", bus.EXT_GNT, 1);
        chk("idle_grant_en", bus.MEM_EN, 0);
        tick();
        chk("idle_release_hold", bus.HOLD, 0);
        chk("idle_release_ack", bus.EXT_ACK, 0);

        bus.M3 = 2'b10;
        bus.DATA_ADDR_3 = 11'h155;
        bus.WDATA_3 = 16'hBEEF;
        #1;
        chk("pipe_wr_en", bus.MEM_EN, 1);
        chk("pipe_wr_we", bus.MEM_WE, 1);
        chk("pipe_wr_addr", bus.MEM_ADDR, 11'h155);
        chk("pipe_wr_data", bus.MEM_WDATA, 16'hBEEF);
        bus.M3 = 2'b11;
        #1;
        chk("pipe_m3_11_en", bus.MEM_EN, 0);
        bus.M3 = 2'b01;
        #1;
        chk("pipe_rd_en", bus.MEM_EN, 1);
        chk("pipe_rd_we", bus.MEM_WE, 0);
        tick();
        chk("pipe_hold", bus.HOLD, 0);
        bus.M3 = 2'b00;

        bus.EXT_REQ = 1'b1;
        bus.EXT_WE = 1'b0;
        bus.EXT_ADDR = 11'h010;
        tick();
        chk("rd_drain_hold", bus.HOLD, 1);
        chk("rd_drain_gnt", bus.EXT_GNT, 0);
        tick();
        chk("rd_gnt", bus.EXT_GNT, 1);
        chk("rd_mem_en", bus.MEM_EN, 1);
        chk("rd_mem_we", bus.MEM_WE, 0);
        chk("rd_mem_addr", bus.MEM_ADDR, 11'h010);
        tick();
        bus.EXT_REQ = 1'b0;
        #1;
        chk("rd_ack", bus.EXT_ACK, 1);
        chk("rd_rdata", bus.EXT_RDATA, 16'h1234);
        tick();
        chk("rd_done_hold", bus.HOLD, 0);
        chk("rd_done_ack", bus.EXT_ACK, 0);
        chk("rd_done_rdata", bus.EXT_RDATA, 0);

        bus.EXT_REQ = 1'b1;
        bus.EXT_WE = 1'b1;
        bus.EXT_ADDR = 11'h030;
        bus.EXT_WDATA = 16'h7777;
        tick();
        bus.M3 = 2'b10;
        bus.DATA_ADDR_3 = 11'h020;
        bus.WDATA_3 = 16'h5A5A;
        #1;
        chk("drain_hold", bus.HOLD, 1);
        chk("drain_gnt", bus.EXT_GNT, 0);
        chk("drain_mem_en", bus.MEM_EN, 1);
        chk("drain_mem_we", bus.MEM_WE, 1);
        chk("drain_mem_addr", bus.MEM_ADDR, 11'h020);
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k == 0) bus.M3 = 2'b00;
            #1;
            hold_v[k] = bus.HOLD;
            gnt_v[k] = bus.EXT_GNT;
            ack_v[k] = bus.EXT_ACK;
            if (bus.EXT_ACK) acks++;
            if (k == 0) begin
                chk("burst_first_addr", bus.MEM_ADDR, 11'h030);
                chk("burst_first_we", bus.MEM_WE, 1);
            end
        end
        chk("burst_hold_seq", hold_v, 9'b110001111);
        chk("burst_gnt_seq", gnt_v, 9'b100001111);
        chk("burst_ack_seq", ack_v, 9'b000011110);
        chk("burst_ack_count", acks, 4);
        tick();
        bus.EXT_REQ = 1'b0;
        #1;
        chk("regrant_ack", bus.EXT_ACK, 1);
        tick();
        chk("regrant_release_hold", bus.HOLD, 0);
        chk("drain_write_mem", mem[11'h020], 16'h5A5A);
        chk("ext_write_mem", mem[11'h030], 16'h7777);

        bus.EXT_REQ = 1'b1;
        bus.EXT_WE = 1'b0;
        bus.EXT_ADDR = 11'h010;
        tick();
        tick();
        bus.M3 = 2'b01;
        bus.DATA_ADDR_3 = 11'h040;
        #1;
        chk("conf_before", bus.CONFLICT, 0);
        chk("conf_ext_priority_addr", bus.MEM_ADDR, 11'h010);
        chk("conf_ext_priority_we", bus.MEM_WE, 0);
        tick();
        bus.M3 = 2'b00;
        bus.EXT_REQ = 1'b0;
        #1;
        chk("conf_set", bus.CONFLICT, CONF_EXP);
        tick();
        chk("conf_held", bus.CONFLICT, CONF_EXP);
        chk("conf_held_hold", bus.HOLD, 0);
        RST = 1'b1;
        tick();
        chk("conf_cleared", bus.CONFLICT, 0);
        chk("conf_cleared_hold", bus.HOLD, 0);
        RST = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
